// File: rtl/hilo_commit_unit.sv
// Speculative HI/LO staging between EX and commit: PIPE_DEPTH in-flight slots,
// architectural HI/LO written only at commit, youngest pending value forwarded.
module hilo_commit_unit #(
    parameter int PIPE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        wr_valid_i,
    input  logic [63:0] wr_hilo_i,
    output logic [63:0] hilo_o,
    output logic [63:0] arch_hilo_o,
    output logic        pending_o,
    output logic        commit_valid_o,
    output logic [63:0] commit_hilo_o
);
    localparam int DATA_W = 64;

    // Slot 0 is the youngest (EX+1); slot PIPE_DEPTH-1 is the commit stage.
    logic [PIPE_DEPTH-1:0] slot_vld_q, slot_vld_d;
    logic [DATA_W-1:0]     slot_dat_q [PIPE_DEPTH];
    logic [DATA_W-1:0]     slot_dat_d [PIPE_DEPTH];
    logic [DATA_W-1:0]     arch_q, arch_d;
    logic                  cvld_q, cvld_d;
    logic [DATA_W-1:0]     chilo_q, chilo_d;

    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_dat_d = slot_dat_q;
        arch_d     = arch_q;
        cvld_d     = 1'b0;
        chilo_d    = chilo_q;
        if (flush) begin
            slot_vld_d = '0;
        end else if (!stall) begin
            if (slot_vld_q[PIPE_DEPTH-1]) begin
                arch_d  = slot_dat_q[PIPE_DEPTH-1];
                cvld_d  = 1'b1;
                chilo_d = slot_dat_q[PIPE_DEPTH-1];
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                slot_vld_d[k] = slot_vld_q[k-1];
                slot_dat_d[k] = slot_dat_q[k-1];
            end
            slot_vld_d[0] = wr_valid_i;
            if (wr_valid_i) begin
                slot_dat_d[0] = wr_hilo_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                slot_dat_q[k] <= '0;
            end
            arch_q  <= '0;
            cvld_q  <= 1'b0;
            chilo_q <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_dat_q <= slot_dat_d;
            arch_q     <= arch_d;
            cvld_q     <= cvld_d;
            chilo_q    <= chilo_d;
        end
    end

    // Scan oldest to youngest so the lowest-index valid slot wins.
    always_comb begin
        hilo_o = arch_q;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (slot_vld_q[k]) begin
                hilo_o = slot_dat_q[k];
            end
        end
    end

    assign pending_o      = |slot_vld_q;
    assign arch_hilo_o    = arch_q;
    assign commit_valid_o = cvld_q;
    assign commit_hilo_o  = chilo_q;
endmodule

// File: tb/tb_hilo_commit_unit.sv
// Self-checking bench for hilo_commit_unit: queue-based model of in-flight writes
// and a queue of expected commits popped when the DUT reports a commit.
module tb_hilo_commit_unit;
    localparam int PD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [63:0] wr_hilo_i = '0;
    logic [63:0] hilo_o, arch_hilo_o, commit_hilo_o;
    logic        pending_o, commit_valid_o;

    hilo_commit_unit #(.PIPE_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .wr_valid_i(wr_valid_i), .wr_hilo_i(wr_hilo_i),
        .hilo_o(hilo_o), .arch_hilo_o(arch_hilo_o), .pending_o(pending_o),
        .commit_valid_o(commit_valid_o), .commit_hilo_o(commit_hilo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        int          age;
    } ent_t;

    ent_t        pq[$];
    logic [63:0] cq[$];
    logic [63:0] m_arch = '0;
    logic [63:0] m_chi  = '0;
    logic        m_cv   = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input logic wv, input logic [63:0] wd,
                        input logic st, input logic fl, input logic rs);
        ent_t        e;
        logic [63:0] exp_fwd;
        wr_valid_i = wv;
        wr_hilo_i  = wd;
        stall      = st;
        flush      = fl;
        rst        = rs;
        @(posedge clk);
        if (rs) begin
            pq.delete();
            cq.delete();
            m_arch = '0;
            m_chi  = '0;
            m_cv   = 1'b0;
        end else if (fl) begin
            pq.delete();
            m_cv = 1'b0;
        end else if (st) begin
            m_cv = 1'b0;
        end else begin
            m_cv = 1'b0;
            if (pq.size() > 0 && pq[0].age == PD) begin
                e      = pq.pop_front();
                m_arch = e.d;
                m_chi  = e.d;
                m_cv   = 1'b1;
                cq.push_back(e.d);
            end
            foreach (pq[i]) pq[i].age = pq[i].age + 1;
            if (wv) begin
                e.d   = wd;
                e.age = 1;
                pq.push_back(e);
            end
        end
        #1;
        exp_fwd = (pq.size() > 0) ? pq[pq.size()-1].d : m_arch;
        chk("hilo_o", hilo_o, exp_fwd);
        chk("arch_hilo_o", arch_hilo_o, m_arch);
        chk("pending_o", {63'd0, pending_o}, {63'd0, pq.size() > 0});
        chk("commit_valid_o", {63'd0, commit_valid_o}, {63'd0, m_cv});
        chk("commit_hilo_o", commit_hilo_o, m_chi);
        if (commit_valid_o) begin
            if (cq.size() == 0) chk("commit_spurious", 64'd1, 64'd0);
            else chk("commit_data", commit_hilo_o, cq.pop_front());
        end else if (cq.size() > 0) begin
            chk("commit_missing", 64'd0, cq.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_hilo", hilo_o, 64'd0);
        chk("reset_commit_valid", {63'd0, commit_valid_o}, 64'd0);

        // Single write, commit two edges after acceptance
        step(1'b1, 64'h0000_0001_0000_0002, 1'b0, 1'b0, 1'b0);
        chk("single_fwd", hilo_o, 64'h0000_0001_0000_0002);
        idle(1);
        chk("single_arch_pre", arch_hilo_o, 64'd0);
        idle(1);
        chk("single_arch_post", arch_hilo_o, 64'h0000_0001_0000_0002);
        idle(2);

        // Forwarding priority: youngest wins
        step(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
        chk("prio_fwd", hilo_o, 64'h22);
        idle(1);
        chk("prio_arch1", arch_hilo_o, 64'h11);
        idle(1);
        chk("prio_arch2", arch_hilo_o, 64'h22);
        idle(1);

        // Stall hold; incoming writes ignored while stalled
        step(1'b1, 64'hAA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 64'hDEAD, 1'b1, 1'b0, 1'b0);
        chk("stall_fwd", hilo_o, 64'hAA);
        idle(3);

        // Flush (with stall) kills speculation
        step(1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 64'h7, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        chk("flush_fwd", hilo_o, 64'h5);
        idle(3);
        chk("flush_arch", arch_hilo_o, 64'h5);

        // Flush with incoming write and valid oldest slot
        step(1'b1, 64'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h300, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("flush2_arch", arch_hilo_o, 64'h5);

        // Reset with two valid slots
        step(1'b1, 64'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_arch", arch_hilo_o, 64'd0);
        chk("rst_mid_fwd", hilo_o, 64'd0);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, {$urandom, $urandom},
                 $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);
        end
        idle(PD + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_commit_unit.md
Name: hilo_commit_unit

Overview:
- Owns the architectural HI/LO register pair. Sits directly downstream of the multi-cycle execution unit.
- Accepts each 64-bit HI/LO result produced in EX and carries it speculatively through PIPE_DEPTH in-flight slots, aligned with the EX→commit pipeline.
- Writes the architectural register only at commit.
- Forwards the youngest pending value back to the multi-cycle unit's hilo input, so back-to-back MULT/MADD/MTHI/DIV chains see correct operands.

Parameters:
PIPE_DEPTH, 2, number of in-flight slots between EX acceptance and commit (≥1)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- stall  input  1  pipeline stall; holds all slots and suppresses commit
- flush  input  1  pipeline flush; kills all in-flight slots and suppresses commit
- wr_valid_i  input  1  EX-stage instruction writes HI/LO this cycle
- wr_hilo_i  input  64  value to write, {HI,LO}
- hilo_o  output  64  forwarded HI/LO, {HI,LO}; feeds the multi-cycle unit's hilo input
- arch_hilo_o  output  64  committed architectural {HI,LO}
- pending_o  output  1  at least one slot valid
- commit_valid_o  output  1  registered pulse: a slot committed on the previous edge
- commit_hilo_o  output  64  value committed with commit_valid_o (trace/difftest)

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values:
  - arch_hilo_o = 0.
  - All slot valid bits = 0; all slot data = 0.
  - commit_valid_o = 0, commit_hilo_o = 0.
  - Hence hilo_o = 0 and pending_o = 0.
  - Reset mid-operation discards every pending slot without committing.
- Slots are indexed 0 (youngest, EX+1) to PIPE_DEPTH-1 (oldest, commit stage). Each slot holds a valid bit and a 64-bit data field.
- Per edge, priority is rst > flush > stall > normal.
- flush=1:
  - All slot valid bits ← 0.
  - No commit; arch unchanged; commit_valid_o ← 0.
  - wr_valid_i is ignored.
  - Applies regardless of stall.
- stall=1, flush=0:
  - Every slot holds.
  - No commit; commit_valid_o ← 0.
  - wr_valid_i is ignored; upstream re-presents it after the stall.
- Normal (stall=0, flush=0):
  - If slot[PIPE_DEPTH-1].valid: arch ← slot[PIPE_DEPTH-1].data, commit_valid_o ← 1, commit_hilo_o ← that data.
  - Otherwise: commit_valid_o ← 0 and commit_hilo_o holds.
  - slot[k] ← slot[k-1] for k ≥ 1.
  - slot[0].valid ← wr_valid_i; slot[0].data ← wr_hilo_i if wr_valid_i, else holds.
- Slot data fields are not cleared when a slot is invalid. Only valid bits are meaningful.
- Forwarding (combinational): hilo_o = data of the lowest-index valid slot; arch_hilo_o if no slot is valid.
  - Forwarding does not depend on stall or flush in the current cycle.
  - It does not include wr_hilo_i. The EX producer is never its own consumer in the same cycle.
- pending_o = OR of all slot valid bits, combinational.
- Same-edge commit and acceptance:
  - Both occur.
  - hilo_o after the edge reflects the new slot[0] if valid, else any remaining slot, else the new arch value.
- Commit latency: a write accepted at edge N commits at edge N+PIPE_DEPTH, given no stall or flush in between. arch_hilo_o and commit_valid_o are visible after that edge.
- Full occupancy (all slots valid) is legal. The unit never back-pressures; it has no stall request output.
- Data is treated as an opaque 64-bit value. No arithmetic is performed.

Test Plan:
1. Reset, then single write: wr_valid_i=1, wr_hilo_i=0x0000_0001_0000_0002 at edge 1, PIPE_DEPTH=2 → hilo_o=0x0000_0001_0000_0002 after edge 1; arch_hilo_o=0 after edge 2; arch_hilo_o=that value and commit_valid_o=1 after edge 3 for one cycle.
2. Forwarding priority: writes A=0x11 at edge 1 and B=0x22 at edge 2 → after edge 2, hilo_o=0x22 while slot1=0x11; after edge 3, arch=0x11 and hilo_o=0x22; after edge 4, arch=0x22 and pending_o=0.
3. Stall hold: write 0xAA, then stall=1 for 3 cycles → slots frozen, commit_valid_o=0, hilo_o=0xAA; after release, commit occurs PIPE_DEPTH non-stalled edges after acceptance.
4. Flush kills speculation: arch=0x5, write 0x7, then flush=1 (with stall=1 the same cycle) → pending_o=0, hilo_o=0x5, arch stays 0x5, no commit pulse.
5. Flush while wr_valid_i=1 and the oldest slot is valid → neither the incoming nor the oldest value commits; arch unchanged.
6. Reset mid-operation with 2 valid slots → all outputs 0 the next cycle, commit_valid_o=0.
